// File: rtl/leaf_port_mux.sv
// ============================================================================
// Module   : leaf_port_mux
// Function : Stream switch between a leaf interface and one user kernel.
//            Egress round-robin merges user output channels into one tagged
//            {port, payload} stream; ingress demuxes a tagged stream into
//            per-port show-ahead FIFOs. Single clock (clk_user).
// Option   : LEAF_PORT_MUX_STATS_EN builds the saturating drop counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module leaf_port_mux #(
  parameter int PAYLOAD_BITS    = 32,
  parameter int NUM_PORT_BITS   = 4,
  parameter int NUM_IN_PORTS    = 2,
  parameter int NUM_OUT_PORTS   = 2,
  parameter int FIFO_DEPTH_BITS = 3
) (
  input  logic                                    clk_user,
  input  logic                                    reset,
  // egress: user -> interface
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   eg_din,
  input  logic [NUM_OUT_PORTS-1:0]                eg_vld,
  output logic [NUM_OUT_PORTS-1:0]                eg_ack,
  output logic [NUM_PORT_BITS+PAYLOAD_BITS-1:0]   eg_dout,
  output logic                                    eg_dout_vld,
  input  logic                                    eg_dout_ack,
  // ingress: interface -> user
  input  logic [NUM_PORT_BITS+PAYLOAD_BITS-1:0]   in_din,
  input  logic                                    in_din_vld,
  output logic                                    in_din_ack,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    in_dout,
  output logic [NUM_IN_PORTS-1:0]                 in_vld,
  input  logic [NUM_IN_PORTS-1:0]                 in_ack,
  // statistics
  output logic [15:0]                             drop_cnt
);

  localparam int TW    = NUM_PORT_BITS + PAYLOAD_BITS;
  localparam int OPW   = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam logic [FIFO_DEPTH_BITS:0] FULL_CNT = (FIFO_DEPTH_BITS+1)'(DEPTH);

  // --------------------------------------------------------------------------
  // Egress
  // --------------------------------------------------------------------------
  logic                     eg_vld_q;
  logic [TW-1:0]            eg_dout_q;
  logic [OPW-1:0]           rr_ptr_q;
  logic [OPW-1:0]           rr_ptr_d;
  logic                     eg_load;
  logic                     gnt_vld;
  logic [OPW-1:0]           gnt_idx;
  logic [NUM_PORT_BITS-1:0] gnt_tag;
  logic [PAYLOAD_BITS-1:0]  gnt_data;

  assign eg_load = !reset && (!eg_vld_q || eg_dout_ack);

  // Two passes give rotating priority: channels at/after the pointer first,
  // then the wrapped-around channels below it.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    gnt_tag  = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (!gnt_vld && eg_vld[i] && (OPW'(i) >= rr_ptr_q)) begin
        gnt_vld  = 1'b1;
        gnt_idx  = OPW'(i);
        gnt_tag  = NUM_PORT_BITS'(i);
        gnt_data = eg_din[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (!gnt_vld && eg_vld[i]) begin
        gnt_vld  = 1'b1;
        gnt_idx  = OPW'(i);
        gnt_tag  = NUM_PORT_BITS'(i);
        gnt_data = eg_din[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  always_comb begin
    eg_ack = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      eg_ack[i] = eg_load && gnt_vld && (gnt_idx == OPW'(i));
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (eg_load && gnt_vld) begin
      if (gnt_idx == OPW'(NUM_OUT_PORTS - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_user) begin
    if (reset) begin
      eg_vld_q  <= 1'b0;
      eg_dout_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (eg_load) begin
        eg_vld_q <= gnt_vld;
        if (gnt_vld) begin
          eg_dout_q <= {gnt_tag, gnt_data};
        end
      end
    end
  end

  assign eg_dout     = eg_dout_q;
  assign eg_dout_vld = eg_vld_q;

  // --------------------------------------------------------------------------
  // Ingress
  // --------------------------------------------------------------------------
  logic [NUM_PORT_BITS-1:0] in_port;
  logic [PAYLOAD_BITS-1:0]  in_payload;
  logic                     port_ok;
  logic                     sel_full;
  logic                     in_take;
  logic [NUM_IN_PORTS-1:0]  fifo_full;
  logic [NUM_IN_PORTS-1:0]  fifo_push;
  logic [NUM_IN_PORTS-1:0]  fifo_pop;

  assign in_port    = in_din[TW-1 -: NUM_PORT_BITS];
  assign in_payload = in_din[PAYLOAD_BITS-1:0];
  assign port_ok    = int'(in_port) < NUM_IN_PORTS;

  always_comb begin
    sel_full = 1'b0;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      if (in_port == NUM_PORT_BITS'(i)) begin
        sel_full = fifo_full[i];
      end
    end
  end

  // A full FIFO refuses even when popped this cycle: the slot frees next cycle.
  assign in_din_ack = !reset && (!port_ok || !sel_full);
  assign in_take    = in_din_vld && in_din_ack;

  always_comb begin
    fifo_push = '0;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      fifo_push[i] = in_take && (in_port == NUM_PORT_BITS'(i));
    end
  end

  for (genvar gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_fifo
    logic [PAYLOAD_BITS-1:0]    mem_q [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_q;
    logic [FIFO_DEPTH_BITS-1:0] rd_q;
    logic [FIFO_DEPTH_BITS:0]   cnt_q;
    logic [FIFO_DEPTH_BITS:0]   cnt_d;

    assign fifo_full[gi] = (cnt_q == FULL_CNT);
    assign in_vld[gi]    = (cnt_q != '0);
    assign fifo_pop[gi]  = in_vld[gi] && in_ack[gi];
    assign in_dout[gi*PAYLOAD_BITS +: PAYLOAD_BITS] = mem_q[rd_q];

    always_comb begin
      cnt_d = cnt_q;
      if (fifo_push[gi] && !fifo_pop[gi]) begin
        cnt_d = cnt_q + 1'b1;
      end else if (!fifo_push[gi] && fifo_pop[gi]) begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    always_ff @(posedge clk_user) begin
      if (reset) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
        if (fifo_push[gi]) begin
          wr_q <= wr_q + 1'b1;
        end
        if (fifo_pop[gi]) begin
          rd_q <= rd_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_user) begin
      if (fifo_push[gi]) begin
        mem_q[wr_q] <= in_payload;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Drop statistics
  // --------------------------------------------------------------------------
`ifdef LEAF_PORT_MUX_STATS_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk_user) begin
    if (reset) begin
      drop_q <= '0;
    end else if (in_take && !port_ok && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule

`default_nettype wire
